// File: rtl/dm_responder.sv
// dm_responder: single-port word memory behind a valid/ready request port.
// Each request gets one response pulse after a fixed wait, returns the word
// as it was before the request, merges enabled write lanes, and reports
// every committed write on a log port.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wr_log_valid,
    output logic [31:0] wr_log_addr,
    output logic [31:0] wr_log_data
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_32  = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [3:0]  byteen_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic [31:0] offset;
    logic [31:0] idx32;
    logic [IDX_W-1:0] idx;
    logic        in_range;
    logic [31:0] old_word;
    logic [31:0] merged;
    logic        do_resp;
    logic        do_write;

    assign accept = req_valid && req_ready;

    // FSM state and wait counter; reset wins over any accept in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; only meaningful while the FSM is busy, so left unreset
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= req_addr;
            byteen_q <= req_byteen;
            wdata_q  <= req_wdata;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down to 1, RESP lasts one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address decode, read-before-write lookup and lane merge of the held request
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        idx32    = offset >> 2;
        in_range = (addr_q >= BASE_ADDR) && (idx32 < DEPTH_32);
        idx      = idx32[IDX_W-1:0];
        // Guard the lookup so a truncated index of a bad address never aliases a real word
        old_word = in_range ? mem_q[idx] : 32'd0;
        merged   = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // A response in flight is dropped the moment reset is seen
    assign do_resp  = (state_q == ST_RESP) && !reset;
    assign do_write = do_resp && in_range && (byteen_q != 4'b0000);

    assign resp_valid   = do_resp;
    assign resp_err     = do_resp && !in_range;
    assign resp_rdata   = (do_resp && in_range) ? old_word : 32'd0;
    assign wr_log_valid = do_write;
    assign wr_log_addr  = do_write ? {addr_q[31:2], 2'b00} : 32'd0;
    assign wr_log_data  = do_write ? merged : 32'd0;

    // Storage: cleared by reset, merged word committed on the edge that ends RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_write) begin
            mem_q[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (no wait, 3-cycle wait,
// offset base with tiny depth) driven through index-selected request lanes.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic        rv   [3];
    logic        rrdy [3];
    logic [31:0] ra   [3];
    logic [3:0]  rb   [3];
    logic [31:0] rw   [3];
    logic        pv   [3];
    logic [31:0] pd   [3];
    logic        pe   [3];
    logic        lv   [3];
    logic [31:0] la   [3];
    logic [31:0] ld   [3];

    int n_chk;
    int n_fail;

    dm_responder #(.DEPTH_WORDS(3072), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_ready(rrdy[0]), .req_addr(ra[0]),
        .req_byteen(rb[0]), .req_wdata(rw[0]),
        .resp_valid(pv[0]), .resp_rdata(pd[0]), .resp_err(pe[0]),
        .wr_log_valid(lv[0]), .wr_log_addr(la[0]), .wr_log_data(ld[0])
    );

    dm_responder #(.DEPTH_WORDS(3072), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_ready(rrdy[1]), .req_addr(ra[1]),
        .req_byteen(rb[1]), .req_wdata(rw[1]),
        .resp_valid(pv[1]), .resp_rdata(pd[1]), .resp_err(pe[1]),
        .wr_log_valid(lv[1]), .wr_log_addr(la[1]), .wr_log_data(ld[1])
    );

    dm_responder #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(1)) ub (
        .clk(clk), .reset(reset),
        .req_valid(rv[2]), .req_ready(rrdy[2]), .req_addr(ra[2]),
        .req_byteen(rb[2]), .req_wdata(rw[2]),
        .resp_valid(pv[2]), .resp_rdata(pd[2]), .resp_err(pe[2]),
        .wr_log_valid(lv[2]), .wr_log_addr(la[2]), .wr_log_data(ld[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waitc(input int d);
        case (d)
            0: return 0;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    // One request on lane d; checks ready/latency framing and returns the response fields
    task automatic issue(input int d, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output logic wv,
                         output logic [31:0] wa, output logic [31:0] wdo);
        int w;
        w = waitc(d);
        rd = 32'd0; er = 1'b0; wv = 1'b0; wa = 32'd0; wdo = 32'd0;
        @(posedge clk); #1;
        rv[d] = 1'b1; ra[d] = a; rb[d] = be; rw[d] = wd;
        @(negedge clk);
        n_chk++;
        if (rrdy[d] !== 1'b1) begin
            n_fail++; $display("FAIL ready_idle d%0d got %b exp 1", d, rrdy[d]);
        end
        @(posedge clk); #1;
        // Inputs change while busy; the held request must not see them
        rv[d] = 1'b0; ra[d] = ~a; rb[d] = ~be; rw[d] = ~wd;
        for (int k = 1; k <= w + 1; k++) begin
            @(negedge clk);
            n_chk++;
            if (pv[d] !== (k == w + 1)) begin
                n_fail++; $display("FAIL resp_timing d%0d cyc T+%0d got %b exp %b", d, k, pv[d], (k == w + 1));
            end
            n_chk++;
            if (rrdy[d] !== 1'b0) begin
                n_fail++; $display("FAIL ready_busy d%0d cyc T+%0d got %b exp 0", d, k, rrdy[d]);
            end
            if (k == w + 1) begin
                rd = pd[d]; er = pe[d]; wv = lv[d]; wa = la[d]; wdo = ld[d];
            end else begin
                @(posedge clk);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (rrdy[d] !== 1'b1 || pv[d] !== 1'b0 || lv[d] !== 1'b0 || pd[d] !== 32'd0 ||
            pe[d] !== 1'b0 || la[d] !== 32'd0 || ld[d] !== 32'd0) begin
            n_fail++;
            $display("FAIL after_resp d%0d got rdy=%b pv=%b lv=%b pd=%h pe=%b la=%h ld=%h exp rdy=1 rest 0",
                     d, rrdy[d], pv[d], lv[d], pd[d], pe[d], la[d], ld[d]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0; ra[d] = 32'd0; rb[d] = 4'd0; rw[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (rrdy[d] !== 1'b1 || pv[d] !== 1'b0 || pd[d] !== 32'd0 || pe[d] !== 1'b0 ||
                lv[d] !== 1'b0 || la[d] !== 32'd0 || ld[d] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_state d%0d got rdy=%b pv=%b pd=%h pe=%b lv=%b la=%h ld=%h exp rdy=1 rest 0",
                         d, rrdy[d], pv[d], pd[d], pe[d], lv[d], la[d], ld[d]);
            end
        end
    endtask

    task automatic test_read_after_reset();
        logic [31:0] rd, wa, wdo; logic er, wv;
        issue(0, 32'h10, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'd0 || er !== 1'b0 || wv !== 1'b0) begin
            n_fail++; $display("FAIL first_read got rd=%h er=%b wv=%b exp 0 0 0", rd, er, wv);
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd, wa, wdo; logic er, wv;
        issue(0, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'd0 || er !== 1'b0 || wv !== 1'b1 || wa !== 32'h10 || wdo !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL full_write got rd=%h er=%b wv=%b wa=%h wd=%h exp 0 0 1 10 deadbeef", rd, er, wv, wa, wdo);
        end
        issue(0, 32'h12, 4'b1100, 32'h12340000, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || wv !== 1'b1 || wa !== 32'h10 || wdo !== 32'h1234BEEF) begin
            n_fail++; $display("FAIL upper_lanes got rd=%h er=%b wv=%b wa=%h wd=%h exp deadbeef 0 1 10 1234beef", rd, er, wv, wa, wdo);
        end
        issue(0, 32'h10, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'h1234BEEF || er !== 1'b0 || wv !== 1'b0 || wa !== 32'd0 || wdo !== 32'd0) begin
            n_fail++; $display("FAIL merged_read got rd=%h er=%b wv=%b wa=%h wd=%h exp 1234beef 0 0 0 0", rd, er, wv, wa, wdo);
        end
    endtask

    task automatic test_sparse_lanes();
        logic [31:0] rd, wa, wdo; logic er, wv;
        issue(0, 32'h20, 4'b1111, 32'h11223344, rd, er, wv, wa, wdo);
        issue(0, 32'h20, 4'b0101, 32'hAABBCCDD, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'h11223344 || wv !== 1'b1 || wa !== 32'h20 || wdo !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL sparse_lanes got rd=%h wv=%b wa=%h wd=%h exp 11223344 1 20 11bb33dd", rd, wv, wa, wdo);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, wa, wdo; logic er, wv;
        issue(0, 32'h0, 4'b1111, 32'hCAFEF00D, rd, er, wv, wa, wdo);
        issue(0, 32'h3000, 4'b1111, 32'h99999999, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0 || wv !== 1'b0 || wa !== 32'd0 || wdo !== 32'd0) begin
            n_fail++; $display("FAIL oor_write got er=%b rd=%h wv=%b wa=%h wd=%h exp 1 0 0 0 0", er, rd, wv, wa, wdo);
        end
        issue(0, 32'h0, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            n_fail++; $display("FAIL oor_no_alias got rd=%h er=%b exp cafef00d 0", rd, er);
        end
        issue(0, 32'h2FFE, 4'b0011, 32'h0000A55A, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b0 || wv !== 1'b1 || wa !== 32'h2FFC || wdo !== 32'h0000A55A) begin
            n_fail++; $display("FAIL last_word got er=%b wv=%b wa=%h wd=%h exp 0 1 2ffc 0000a55a", er, wv, wa, wdo);
        end
        issue(0, 32'hFFFF_FFFC, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL top_addr got er=%b rd=%h exp 1 0", er, rd);
        end
    endtask

    task automatic test_base_offset();
        logic [31:0] rd, wa, wdo; logic er, wv;
        issue(2, 32'h100C, 4'b1111, 32'h01020304, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b0 || wv !== 1'b1 || wa !== 32'h100C || wdo !== 32'h01020304 || rd !== 32'd0) begin
            n_fail++; $display("FAIL base_write got er=%b wv=%b wa=%h wd=%h rd=%h exp 0 1 100c 01020304 0", er, wv, wa, wdo, rd);
        end
        issue(2, 32'h0FFC, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL below_base got er=%b rd=%h exp 1 0", er, rd);
        end
        issue(2, 32'h1010, 4'b1111, 32'hFFFFFFFF, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b1 || wv !== 1'b0) begin
            n_fail++; $display("FAIL past_depth got er=%b wv=%b exp 1 0", er, wv);
        end
        issue(2, 32'h1000, 4'b0011, 32'h5555ABCD, rd, er, wv, wa, wdo);
        n_chk++;
        if (er !== 1'b0 || wv !== 1'b1 || wa !== 32'h1000 || wdo !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL base_word0 got er=%b wv=%b wa=%h wd=%h exp 0 1 1000 0000abcd", er, wv, wa, wdo);
        end
        issue(2, 32'h100F, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'h01020304 || er !== 1'b0) begin
            n_fail++; $display("FAIL low_bits_ignored got rd=%h er=%b exp 01020304 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        // Valid held high on the 3-wait instance: accept at T, response at T+4, re-accept at T+5
        @(posedge clk); #1;
        rv[1] = 1'b1; ra[1] = 32'h44; rb[1] = 4'b0000; rw[1] = 32'h0;
        @(negedge clk);
        n_chk++;
        if (rrdy[1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_T got %b exp 1", rrdy[1]);
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            if (k == 6) begin
                #1 rv[1] = 1'b0;
            end
            @(negedge clk);
            n_chk++;
            if (rrdy[1] !== (k == 5 || k == 10) || pv[1] !== (k == 4 || k == 9)) begin
                n_fail++;
                $display("FAIL b2b_cycle T+%0d got rdy=%b pv=%b exp rdy=%b pv=%b",
                         k, rrdy[1], pv[1], (k == 5 || k == 10), (k == 4 || k == 9));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, wa, wdo; logic er, wv;
        @(posedge clk); #1;
        rv[1] = 1'b1; ra[1] = 32'h40; rb[1] = 4'b1111; rw[1] = 32'h55;
        @(posedge clk); #1 rv[1] = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            n_chk++;
            if (pv[1] !== 1'b0 || lv[1] !== 1'b0) begin
                n_fail++; $display("FAIL abort_quiet T+%0d got pv=%b lv=%b exp 0 0", k, pv[1], lv[1]);
            end
            @(posedge clk);
        end
        // Reset asserted in the same cycle as an otherwise valid accept
        #1 rv[1] = 1'b1; ra[1] = 32'h40; rb[1] = 4'b1111; rw[1] = 32'h77; reset = 1'b1;
        @(posedge clk); #1 rv[1] = 1'b0; reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_chk++;
            if (pv[1] !== 1'b0 || rrdy[1] !== 1'b1) begin
                n_fail++; $display("FAIL reset_priority cyc %0d got pv=%b rdy=%b exp 0 1", k, pv[1], rrdy[1]);
            end
            @(posedge clk);
        end
        issue(1, 32'h40, 4'b0000, 32'h0, rd, er, wv, wa, wdo);
        n_chk++;
        if (rd !== 32'd0 || er !== 1'b0 || wv !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_commit got rd=%h er=%b wv=%b exp 0 0 0", rd, er, wv);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_read_after_reset();
        test_byte_merge();
        test_sparse_lanes();
        test_out_of_range();
        test_base_offset();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072: number of 32-bit words stored.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 0: extra cycles between accept and response; legal range 0..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 req_byteen  input  4  write lane enables; lane i covers bits [8i+7:8i]; 4'b0000 means read.
REQ-010 req_wdata  input  32  lane-positioned write data.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  stored word before any write from this request.
REQ-013 resp_err  output  1  address out of range; qualified by resp_valid.
REQ-014 wr_log_valid  output  1  committed-write pulse.
REQ-015 wr_log_addr  output  32  word-aligned byte address of the committed write.
REQ-016 wr_log_data  output  32  full merged word after the write.

Function
REQ-017 The block SHALL implement the FSM states IDLE, WAIT, and RESP.
REQ-018 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-019 The block SHALL accept a request only when req_valid and req_ready are both 1, and SHALL then latch req_addr, req_byteen, and req_wdata.
REQ-020 On accept, the FSM SHALL move to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-021 In WAIT, a 4-bit counter loaded with WAIT_CYCLES on accept SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-022 RESP SHALL last exactly one cycle and SHALL then return to IDLE.
REQ-023 Latency: for an accept in cycle T, resp_valid SHALL be 1 in cycle T+1+WAIT_CYCLES and 0 in all other cycles.
REQ-024 Throughput: one request per WAIT_CYCLES+2 cycles; no back-to-back accepts.
REQ-025 Word index SHALL be (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic with wrap-around.
REQ-026 A request SHALL be out of range when addr < BASE_ADDR or index >= DEPTH_WORDS.
REQ-027 For an out-of-range request: resp_err=1, resp_rdata=0, no storage change, and no wr_log pulse.
REQ-028 resp_rdata SHALL be the word stored before this request's write (read-before-write).
REQ-029 Byte merge: each enabled lane SHALL take req_wdata; each disabled lane SHALL keep the stored byte.
REQ-030 Any byteen pattern is legal, including non-contiguous patterns such as 4'b0101.
REQ-031 The merged word SHALL be committed on the edge that ends the RESP cycle.
REQ-032 A request accepted in the cycle after RESP SHALL observe the committed data.
REQ-033 wr_log_valid SHALL pulse coincident with resp_valid only for in-range requests with byteen != 0.
REQ-034 wr_log_addr SHALL equal {req_addr[31:2], 2'b00}, and wr_log_data SHALL equal the merged word.
REQ-035 When resp_valid is 0: resp_rdata, resp_err, wr_log_valid, wr_log_addr, and wr_log_data SHALL all be 0.
REQ-036 Changes on req_* inputs while req_ready is 0 SHALL be ignored.

Reset
REQ-037 While reset is 1 at a clock edge: FSM to IDLE, counter to 0, all storage words to 0.
REQ-038 The cycle after reset: req_ready=1 and every other output is 0.
REQ-039 Reset during WAIT or RESP SHALL abort the request: no commit, and no resp_valid or wr_log pulse for it.
REQ-040 Reset SHALL take priority over an accept in the same cycle.

Verification
REQ-041 Scenario, WAIT_CYCLES=0, after reset: read addr 0x10 -> resp_valid at T+1, rdata=0, err=0, wr_log_valid=0, req_ready back to 1 at T+2.
REQ-042 Scenario: write 0x10, byteen 4'b1111, data 0xDEADBEEF; then write 0x12, byteen 4'b1100, data 0x12340000; then read 0x10 -> second response rdata=0xDEADBEEF with wr_log_data=0x1234BEEF; read returns 0x1234BEEF.
REQ-043 Scenario: write 0x20, byteen 4'b0101, data 0xAABBCCDD onto stored 0x11223344 -> wr_log_data=0x11BB33DD, wr_log_addr=0x20.
REQ-044 Scenario, DEPTH_WORDS=3072: write addr 0x3000, byteen 4'b1111 -> resp_err=1, rdata=0, no wr_log pulse; a following read of 0x0000 returns an unchanged word.
REQ-045 Scenario, WAIT_CYCLES=3: accept in cycle T -> req_ready=0 for T+1..T+4, resp_valid only at T+4; a req_valid held high is accepted again at T+5.
REQ-046 Scenario, WAIT_CYCLES=3: write 0x40 with data 0x55, reset asserted at T+2 -> no resp_valid, no wr_log pulse; a later read of 0x40 returns 0.
